tt_mux4_sel_ctrl: RTL and testbench

- Select-line controller directly upstream of a LEVELS-deep tree of tt_cell_mux4 cells; drives every `s[1:0]` in the tree from one registered select bus.
- Loads a tree address serially (shift plus commit) or auto-scans through all 4^LEVELS inputs with a programmable dwell.
- Flags one settle cycle after every select change, so downstream samplers only capture a stable mux output.

---
 rtl/tt_mux4_sel_ctrl_if.sv | 26 ++
 rtl/tt_mux4_sel_ctrl.sv | 83 ++++++++
 tb/tb_tt_mux4_sel_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tt_mux4_sel_ctrl_if.sv
// Control and select bus between a sequencer (master) and the mux4 tree select
// controller (slave).
interface tt_mux4_sel_ctrl_if #(
  parameter int LEVELS  = 3,
  parameter int DWELL_W = 8
);
  logic                  ctrl_data;
  logic                  ctrl_shift;
  logic                  ctrl_commit;
  logic                  scan_en;
  logic [DWELL_W-1:0]    dwell;
  logic [2*LEVELS-1:0]   sel;
  logic                  sel_valid;
  logic                  busy;
  logic                  wrap;

  modport master (
    output ctrl_data, ctrl_shift, ctrl_commit, scan_en, dwell,
    input  sel, sel_valid, busy, wrap
  );

  modport slave (
    input  ctrl_data, ctrl_shift, ctrl_commit, scan_en, dwell,
    output sel, sel_valid, busy, wrap
  );
endinterface

// File: rtl/tt_mux4_sel_ctrl.sv
// Registered select-bus controller for a LEVELS-deep mux4 tree: serial address
// load with commit, or auto-scan with a programmable dwell and one settle cycle.
module tt_mux4_sel_ctrl #(
  parameter int LEVELS  = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  tt_mux4_sel_ctrl_if.slave     bus
);
  localparam int SW = 2 * LEVELS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      sr, sr_nxt;
  logic [SW-1:0]      sel_q, sel_nxt;
  logic [DWELL_W-1:0] dcnt, dcnt_nxt;
  logic               wrap_q, wrap_nxt;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    sel_nxt   = sel_q;
    dcnt_nxt  = '0;
    wrap_nxt  = 1'b0;

    // Shift is independent of commit; a commit below still sees the pre-shift sr.
    if (bus.ctrl_shift) begin
      sr_nxt = {bus.ctrl_data, sr[SW-1:1]};
    end

    if (bus.ctrl_commit) begin
      sel_nxt   = sr;
      state_nxt = SETTLE;
    end else begin
      unique case (state)
        IDLE:   state_nxt = IDLE;
        SETTLE: state_nxt = HOLD;
        HOLD: begin
          if (bus.scan_en) begin
            // >= so that lowering dwell below the running count advances at once.
            if (dcnt >= bus.dwell) begin
              sel_nxt   = sel_q + SW'(1);
              wrap_nxt  = &sel_q;
              state_nxt = SETTLE;
            end else begin
              dcnt_nxt = dcnt + DWELL_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      sel_q  <= '0;
      dcnt   <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      sel_q  <= sel_nxt;
      dcnt   <= dcnt_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = (state == HOLD);
  assign bus.busy      = (state == SETTLE);
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_tt_mux4_sel_ctrl.sv
// Bench for tt_mux4_sel_ctrl: step-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tt_mux4_sel_ctrl;
  localparam int LEVELS  = 3;
  localparam int DWELL_W = 8;
  localparam int SW      = 2 * LEVELS;
  localparam int NSEL    = 1 << SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  tt_mux4_sel_ctrl_if #(.LEVELS(LEVELS), .DWELL_W(DWELL_W)) bus ();

  tt_mux4_sel_ctrl #(.LEVELS(LEVELS), .DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a mode (idle / settling / holding), the address, and how many valid
  // cycles of the current scan step have elapsed.
  int m_sr = 0, m_sel = 0, m_mode = 0, m_held = 0;
  bit m_wrap = 1'b0;

  always @(posedge clk) begin
    int pre_sr;
    m_wrap = 1'b0;
    if (rst) begin
      m_sr = 0; m_sel = 0; m_mode = 0; m_held = 0;
    end else begin
      pre_sr = m_sr;
      if (bus.ctrl_shift) m_sr = (m_sr >> 1) + (int'(bus.ctrl_data) << (SW - 1));
      if (bus.ctrl_commit) begin
        m_sel = pre_sr; m_mode = 1; m_held = 0;
      end else if (m_mode == 1) begin
        m_mode = 2; m_held = 0;
      end else if (m_mode == 2) begin
        if (!bus.scan_en) m_held = 0;
        else begin
          m_held++;
          if (m_held > int'(bus.dwell)) begin
            m_sel  = (m_sel + 1) % NSEL;
            m_wrap = (m_sel == 0);
            m_mode = 1; m_held = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_sel",   32'(bus.sel),       32'(m_sel));
      check("model_valid", 32'(bus.sel_valid), 32'(m_mode == 2));
      check("model_busy",  32'(bus.busy),      32'(m_mode == 1));
      check("model_wrap",  32'(bus.wrap),      32'(m_wrap));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_sr(input logic [SW-1:0] v);
    for (int i = 0; i < SW; i++) begin
      bus.ctrl_data  = v[i];
      bus.ctrl_shift = 1'b1;
      step();
    end
    bus.ctrl_shift = 1'b0;
    bus.ctrl_data  = 1'b0;
  endtask

  task automatic commit_now();
    bus.ctrl_commit = 1'b1;
    step();
    bus.ctrl_commit = 1'b0;
  endtask

  logic [SW-1:0] exp_sel [13] = '{6'h3E, 6'h3E, 6'h3E, 6'h3E, 6'h3F, 6'h3F, 6'h3F,
                                  6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01};

  initial begin
    int cnt;
    bus.ctrl_data = 1'b0; bus.ctrl_shift = 1'b0; bus.ctrl_commit = 1'b0;
    bus.scan_en = 1'b0;   bus.dwell = '0;
    rst = 1'b1;
    step(2);
    chk_en = 1'b1;
    rst = 1'b0;

    // Idle: scan_en alone must not leave IDLE.
    bus.scan_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_sel",   32'(bus.sel),       32'h0);
      check("idle_valid", 32'(bus.sel_valid), 32'h0);
      check("idle_busy",  32'(bus.busy),      32'h0);
      check("idle_wrap",  32'(bus.wrap),      32'h0);
    end
    bus.scan_en = 1'b0;

    // Serial load 1,0,1,1,0,0 LSB first.
    load_sr(6'b001101);
    commit_now();
    check("load_sel",    32'(bus.sel),       32'h0D);
    check("load_busy",   32'(bus.busy),      32'h1);
    check("load_valid0", 32'(bus.sel_valid), 32'h0);
    step();
    check("load_valid1", 32'(bus.sel_valid), 32'h1);

    // Shift and commit together: commit takes pre-shift value.
    load_sr(6'h2A);
    bus.ctrl_data = 1'b1; bus.ctrl_shift = 1'b1; bus.ctrl_commit = 1'b1;
    step();
    bus.ctrl_data = 1'b0; bus.ctrl_shift = 1'b0; bus.ctrl_commit = 1'b0;
    check("shc_sel", 32'(bus.sel), 32'h2A);
    step();
    commit_now();
    check("shc_sr_after", 32'(bus.sel), 32'h35);
    check("recommit_busy", 32'(bus.busy), 32'h1);
    step();

    // Scan across the wrap with dwell=2.
    load_sr(6'h3E);
    bus.dwell = 8'd2; bus.scan_en = 1'b1;
    commit_now();
    for (int k = 0; k < 13; k++) begin
      check("scan_sel",   32'(bus.sel),       32'(exp_sel[k]));
      check("scan_busy",  32'(bus.busy),      32'((k % 4) == 0));
      check("scan_valid", 32'(bus.sel_valid), 32'((k % 4) != 0));
      check("scan_wrap",  32'(bus.wrap),      32'(k == 8));
      step();
    end
    bus.scan_en = 1'b0;
    step(2);

    // Commit coinciding with the scan-advance cycle.
    load_sr(6'h10);
    commit_now();
    step();
    load_sr(6'h07);
    check("hold_noscan_sel", 32'(bus.sel), 32'h10);
    bus.scan_en = 1'b1;
    step(2);
    bus.ctrl_commit = 1'b1;
    step();
    bus.ctrl_commit = 1'b0;
    check("coinc_sel",  32'(bus.sel),  32'h07);
    check("coinc_busy", 32'(bus.busy), 32'h1);
    check("coinc_wrap", 32'(bus.wrap), 32'h0);

    // Drop scan_en mid-dwell, then re-enable for a full dwell.
    step(2);
    bus.scan_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("drop_sel",   32'(bus.sel),       32'h07);
      check("drop_valid", 32'(bus.sel_valid), 32'h1);
    end
    bus.scan_en = 1'b1;
    step(2);
    check("reen_sel",   32'(bus.sel),       32'h07);
    check("reen_valid", 32'(bus.sel_valid), 32'h1);
    step();
    check("reen_adv",  32'(bus.sel),  32'h08);
    check("reen_busy", 32'(bus.busy), 32'h1);

    // Reset while in SETTLE.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_sel",   32'(bus.sel),       32'h0);
    check("rst_valid", 32'(bus.sel_valid), 32'h0);
    check("rst_busy",  32'(bus.busy),      32'h0);
    check("rst_wrap",  32'(bus.wrap),      32'h0);
    step(2);
    check("rst_idle_valid", 32'(bus.sel_valid), 32'h0);

    // dwell=0: advance every two cycles.
    load_sr(6'h05);
    bus.dwell = 8'd0;
    commit_now();
    step(4);
    check("dwell0_sel",  32'(bus.sel),  32'h07);
    check("dwell0_busy", 32'(bus.busy), 32'h1);

    // Live dwell decrease below the running count advances at once.
    load_sr(6'h20);
    bus.dwell = 8'd5;
    commit_now();
    step(4);
    check("dec_pre_valid", 32'(bus.sel_valid), 32'h1);
    bus.dwell = 8'd1;
    step();
    check("dec_sel",  32'(bus.sel),  32'h21);
    check("dec_busy", 32'(bus.busy), 32'h1);

    // dwell all-ones gives 256 valid cycles per step.
    bus.dwell = 8'hFF;
    commit_now();
    step();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.sel_valid) break;
      cnt++;
      step();
    end
    check("dwell_max_cycles", 32'(cnt), 32'd256);
    bus.scan_en = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
